free_reg_list: RTL and testbench

Free register list (FRL) for the rename stage. Holds every physical register index not currently mapped or in flight, and presents a fixed window of free indices to the RAT every cycle. The RAT consumes any subset of the window through a per-slot ready mask. Consumed slots are refilled from a circular FIFO, and the ROB pushes released physical registers back into that FIFO at commit.

---
 rtl/free_reg_list.sv | 171 +++++++++++++++++
 tb/tb_free_reg_list.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_reg_list.sv
// rtl/free_reg_list.sv - rename-stage free register list (optional FRL_DOUBLE_FREE_CHECK_EN)
// Presents a SLOTS-wide window of free physical indices to the RAT. Consumed
// or empty slots are refilled from a circular FIFO, and the ROB pushes released
// indices into that FIFO. Defining FRL_DOUBLE_FREE_CHECK_EN adds an is_free
// bitmap that drops double releases and reports them on double_free_err.
module free_reg_list #(
  parameter  int NUM_PHYS_REGS = 64,
  parameter  int INSTR_Q_WIDTH = 1,
  localparam int SLOTS         = 8 * INSTR_Q_WIDTH,
  localparam int FREE_WIDTH    = 4 * INSTR_Q_WIDTH,
  localparam int PW            = $clog2(NUM_PHYS_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic [SLOTS-1:0]              frl_ready,
  output logic [SLOTS-1:0][PW-1:0]      free_register_data,
  output logic                          frl_valid,
  input  logic [FREE_WIDTH-1:0]         free_valid,
  input  logic [FREE_WIDTH-1:0][PW-1:0] free_data,
  output logic [PW:0]                   free_count,
`ifdef FRL_DOUBLE_FREE_CHECK_EN
  output logic                          double_free_err,
`endif
  output logic                          overflow_err
);

  localparam int CNTW = PW + 1;
  localparam logic [CNTW-1:0] DEPTH = CNTW'(NUM_PHYS_REGS);
  localparam logic [CNTW-1:0] INIT_CNT = CNTW'(NUM_PHYS_REGS - 1 - SLOTS);

  logic [SLOTS-1:0][PW-1:0] slot_idx_q, slot_idx_d;
  logic [SLOTS-1:0]         slot_vld_q, slot_vld_d;
  logic [PW-1:0]            fifo_q [NUM_PHYS_REGS];
  logic [PW-1:0]            fifo_d [NUM_PHYS_REGS];
  logic [CNTW-1:0]          head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic                     overflow_q, overflow_d;

  logic [CNTW-1:0]          rank, pops, pushes, base, head_sum, tail_sum;
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic                     accept;

`ifdef FRL_DOUBLE_FREE_CHECK_EN
  logic [NUM_PHYS_REGS-1:0] is_free_q, is_free_d;
  logic [NUM_PHYS_REGS-1:0] pop_mask, push_mask, seen;
  logic                     dfe_q, dfe_d;
`endif

  // Refill: rank needing slots in ascending order and hand them FIFO entries
  // as they stood at the start of the cycle; the rest go invalid.
  always_comb begin
    slot_idx_d = slot_idx_q;
    slot_vld_d = slot_vld_q;
    rank       = '0;
    rd_ptr     = '0;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
    pop_mask   = '0;
`endif
    for (int k = 0; k < SLOTS; k++) begin
      if (frl_ready[k] || !slot_vld_q[k]) begin
        if (rank < count_q) begin
          rd_ptr        = PW'(head_q + rank);
          slot_idx_d[k] = fifo_q[rd_ptr];
          slot_vld_d[k] = 1'b1;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
          pop_mask[fifo_q[rd_ptr]] = 1'b1;
`endif
        end else begin
          slot_vld_d[k] = 1'b0;
        end
        rank = rank + CNTW'(1);
      end
    end
    pops     = (rank < count_q) ? rank : count_q;
    head_sum = head_q + pops;
    head_d   = (head_sum >= DEPTH) ? head_sum - DEPTH : head_sum;
  end

  // Release: append strobed lanes at tail in lane order, dropping any push
  // that would find the FIFO already full.
  always_comb begin
    fifo_d     = fifo_q;
    overflow_d = overflow_q;
    base       = count_q - pops;
    pushes     = '0;
    wr_ptr     = '0;
    accept     = 1'b0;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
    seen       = is_free_q;
    push_mask  = '0;
    dfe_d      = dfe_q;
`endif
    for (int l = 0; l < FREE_WIDTH; l++) begin
      accept = free_valid[l];
`ifdef FRL_DOUBLE_FREE_CHECK_EN
      // p0 is reserved; an index already free (or pushed by an earlier lane) is a double free
      if (accept && (seen[free_data[l]] || free_data[l] == '0)) begin
        accept = 1'b0;
        dfe_d  = 1'b1;
      end
`endif
      if (accept) begin
        if (base + pushes >= DEPTH) begin
          overflow_d = 1'b1;
        end else begin
          wr_ptr         = PW'(tail_q + pushes);
          fifo_d[wr_ptr] = free_data[l];
          pushes         = pushes + CNTW'(1);
`ifdef FRL_DOUBLE_FREE_CHECK_EN
          seen[free_data[l]]      = 1'b1;
          push_mask[free_data[l]] = 1'b1;
`endif
        end
      end
    end
    tail_sum = tail_q + pushes;
    tail_d   = (tail_sum >= DEPTH) ? tail_sum - DEPTH : tail_sum;
    count_d  = base + pushes;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
    is_free_d = (is_free_q & ~pop_mask) | push_mask;
`endif
  end

  // Free count is valid window slots plus FIFO occupancy, from registered state only.
  always_comb begin
    free_count = count_q;
    for (int k = 0; k < SLOTS; k++) begin
      free_count = free_count + {{PW{1'b0}}, slot_vld_q[k]};
    end
  end

  assign free_register_data = slot_idx_q;
  assign frl_valid          = &slot_vld_q;
  assign overflow_err       = overflow_q;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
  assign double_free_err    = dfe_q;
`endif

  // State registers; reset reloads the window with p1..pSLOTS and the FIFO with the rest.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int k = 0; k < SLOTS; k++) begin
        slot_idx_q[k] <= PW'(k + 1);
      end
      slot_vld_q <= '1;
      for (int j = 0; j < NUM_PHYS_REGS; j++) begin
        fifo_q[j] <= (j < NUM_PHYS_REGS - 1 - SLOTS) ? PW'(SLOTS + 1 + j) : '0;
      end
      head_q     <= '0;
      tail_q     <= INIT_CNT;
      count_q    <= INIT_CNT;
      overflow_q <= 1'b0;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
      is_free_q  <= {{(NUM_PHYS_REGS-1){1'b1}}, 1'b0};
      dfe_q      <= 1'b0;
`endif
    end else begin
      slot_idx_q <= slot_idx_d;
      slot_vld_q <= slot_vld_d;
      fifo_q     <= fifo_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
      is_free_q  <= is_free_d;
      dfe_q      <= dfe_d;
`endif
    end
  end

endmodule

// File: tb/tb_free_reg_list.sv
// tb/tb_free_reg_list.sv - self-checking bench for free_reg_list
module tb_free_reg_list;

  localparam int N     = 64;
  localparam int SLOTS = 8;
  localparam int FW    = 4;
  localparam int PW    = 6;

  logic                    clk = 1'b0;
  logic                    rst_in = 1'b1;
  logic [SLOTS-1:0]        frl_ready = '0;
  logic [SLOTS-1:0][PW-1:0] free_register_data;
  logic                    frl_valid;
  logic [FW-1:0]           free_valid = '0;
  logic [FW-1:0][PW-1:0]   free_data = '0;
  logic [PW:0]             free_count;
  logic                    overflow_err;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
  logic                    double_free_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  free_reg_list #(.NUM_PHYS_REGS(N), .INSTR_Q_WIDTH(1)) dut (
    .clk                (clk),
    .rst_in             (rst_in),
    .frl_ready          (frl_ready),
    .free_register_data (free_register_data),
    .frl_valid          (frl_valid),
    .free_valid         (free_valid),
    .free_data          (free_data),
    .free_count         (free_count),
`ifdef FRL_DOUBLE_FREE_CHECK_EN
    .double_free_err    (double_free_err),
`endif
    .overflow_err       (overflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of free indices plus the window slots
  int         m_q[$];
  int         m_idx[SLOTS];
  bit [SLOTS-1:0] m_vld;
  bit         m_ovf;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
  bit [N-1:0] m_free;
  bit         m_dfe;
`endif

  function automatic void model_reset();
    m_q.delete();
    for (int j = SLOTS + 1; j < N; j++) m_q.push_back(j);
    for (int k = 0; k < SLOTS; k++) m_idx[k] = k + 1;
    m_vld = '1;
    m_ovf = 1'b0;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
    m_free = '1;
    m_free[0] = 1'b0;
    m_dfe = 1'b0;
`endif
  endfunction

  function automatic void model_step(input logic [SLOTS-1:0] rdy, input logic [FW-1:0] fv,
                                     input logic [FW-1:0][PW-1:0] fd);
    int old_size;
    int popped;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
    bit [N-1:0] chk;
    chk = m_free;
`endif
    old_size = m_q.size();
    popped   = 0;
    for (int k = 0; k < SLOTS; k++) begin
      if (rdy[k] || !m_vld[k]) begin
        if (popped < old_size) begin
          m_idx[k] = m_q.pop_front();
          m_vld[k] = 1'b1;
          popped++;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
          m_free[m_idx[k]] = 1'b0;
`endif
        end else begin
          m_vld[k] = 1'b0;
        end
      end
    end
    for (int l = 0; l < FW; l++) begin
      if (fv[l]) begin
        bit drop;
        drop = 1'b0;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
        if (chk[fd[l]] || fd[l] == 0) begin
          drop  = 1'b1;
          m_dfe = 1'b1;
        end
`endif
        if (!drop) begin
          if (m_q.size() < N) begin
            m_q.push_back(int'(fd[l]));
`ifdef FRL_DOUBLE_FREE_CHECK_EN
            chk[fd[l]]    = 1'b1;
            m_free[fd[l]] = 1'b1;
`endif
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic cycle(input logic [SLOTS-1:0] rdy, input logic [FW-1:0] fv,
                       input logic [FW-1:0][PW-1:0] fd);
    @(negedge clk);
    frl_ready  = rdy;
    free_valid = fv;
    free_data  = fd;
    model_step(rdy, fv, fd);
    @(posedge clk);
    #1;
    frl_ready  = '0;
    free_valid = '0;
  endtask

  // Reset with random traffic on the inputs, which must be discarded
  task automatic do_reset();
    @(negedge clk);
    rst_in     = 1'b1;
    frl_ready  = SLOTS'($urandom);
    free_valid = FW'($urandom);
    free_data  = (FW*PW)'($urandom);
    @(posedge clk);
    #1;
    rst_in     = 1'b0;
    frl_ready  = '0;
    free_valid = '0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < SLOTS; k++) begin
      n_cmp++;
      if (free_register_data[k] !== PW'(k + 1)) begin
        n_fail++;
        $display("FAIL reset_slot%0d: got %0d expected %0d", k, free_register_data[k], k + 1);
      end
    end
    n_cmp++;
    if (frl_valid !== 1'b1) begin n_fail++; $display("FAIL reset_frl_valid: got %b expected 1", frl_valid); end
    n_cmp++;
    if (free_count !== 7'd63) begin n_fail++; $display("FAIL reset_free_count: got %0d expected 63", free_count); end
    n_cmp++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow_err); end
    cycle('0, '0, '0);
    n_cmp++;
    if (free_count !== 7'd63) begin n_fail++; $display("FAIL idle_free_count: got %0d expected 63", free_count); end
    n_cmp++;
    if (free_register_data[7] !== 6'd8) begin n_fail++; $display("FAIL idle_slot7: got %0d expected 8", free_register_data[7]); end
  endtask

  task automatic test_partial_consume();
    do_reset();
    cycle(8'b0000_0101, '0, '0);
    n_cmp++;
    if (free_register_data[0] !== 6'd9) begin n_fail++; $display("FAIL partial_slot0: got %0d expected 9", free_register_data[0]); end
    n_cmp++;
    if (free_register_data[2] !== 6'd10) begin n_fail++; $display("FAIL partial_slot2: got %0d expected 10", free_register_data[2]); end
    n_cmp++;
    if (free_register_data[1] !== 6'd2) begin n_fail++; $display("FAIL partial_slot1: got %0d expected 2", free_register_data[1]); end
    n_cmp++;
    if (free_count !== 7'd61) begin n_fail++; $display("FAIL partial_free_count: got %0d expected 61", free_count); end
    n_cmp++;
    if (frl_valid !== 1'b1) begin n_fail++; $display("FAIL partial_frl_valid: got %b expected 1", frl_valid); end
  endtask

  task automatic test_drain_refill();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle(8'hFF, '0, '0);
      if (i == 7) begin
        for (int k = 0; k < 7; k++) begin
          n_cmp++;
          if (free_register_data[k] !== PW'(57 + k)) begin
            n_fail++;
            $display("FAIL drain7_slot%0d: got %0d expected %0d", k, free_register_data[k], 57 + k);
          end
        end
        n_cmp++;
        if (frl_valid !== 1'b0) begin n_fail++; $display("FAIL drain7_frl_valid: got %b expected 0", frl_valid); end
        n_cmp++;
        if (free_count !== 7'd7) begin n_fail++; $display("FAIL drain7_free_count: got %0d expected 7", free_count); end
      end
    end
    n_cmp++;
    if (free_count !== 7'd0) begin n_fail++; $display("FAIL drain8_free_count: got %0d expected 0", free_count); end
    cycle('0, 4'b1111, {6'd8, 6'd7, 6'd6, 6'd5});
    n_cmp++;
    if (frl_valid !== 1'b0) begin n_fail++; $display("FAIL pushM_frl_valid: got %b expected 0", frl_valid); end
    n_cmp++;
    if (free_count !== 7'd4) begin n_fail++; $display("FAIL pushM_free_count: got %0d expected 4", free_count); end
    cycle('0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (free_register_data[k] !== PW'(5 + k)) begin
        n_fail++;
        $display("FAIL refill_slot%0d: got %0d expected %0d", k, free_register_data[k], 5 + k);
      end
    end
    n_cmp++;
    if (frl_valid !== 1'b0) begin n_fail++; $display("FAIL refill_frl_valid: got %b expected 0", frl_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(8'hFF, '0, '0);
    cycle(8'h3F, '0, '0);
    n_cmp++;
    if (free_count !== 7'd9) begin n_fail++; $display("FAIL sim_setup_free_count: got %0d expected 9", free_count); end
    cycle(8'h01, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd20});
    n_cmp++;
    if (free_register_data[0] !== 6'd63) begin n_fail++; $display("FAIL sim_slot0: got %0d expected 63", free_register_data[0]); end
    n_cmp++;
    if (free_count !== 7'd9) begin n_fail++; $display("FAIL sim_free_count: got %0d expected 9", free_count); end
    cycle(8'h01, '0, '0);
    n_cmp++;
    if (free_register_data[0] !== 6'd20) begin n_fail++; $display("FAIL sim_next_slot0: got %0d expected 20", free_register_data[0]); end
    n_cmp++;
    if (free_count !== 7'd8) begin n_fail++; $display("FAIL sim_next_free_count: got %0d expected 8", free_count); end
  endtask

`ifndef FRL_DOUBLE_FREE_CHECK_EN
  task automatic test_overflow();
    do_reset();
    cycle('0, 4'b1111, {6'd1, 6'd2, 6'd3, 6'd4});
    cycle('0, 4'b0111, {6'd0, 6'd5, 6'd6, 6'd7});
    n_cmp++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b expected 0", overflow_err); end
    n_cmp++;
    if (free_count !== 7'd70) begin n_fail++; $display("FAIL ovf_pre_free_count: got %0d expected 70", free_count); end
    cycle('0, 4'b1111, {6'd11, 6'd10, 6'd9, 6'd8});
    n_cmp++;
    if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow_err); end
    n_cmp++;
    if (free_count !== 7'd72) begin n_fail++; $display("FAIL ovf_free_count: got %0d expected 72", free_count); end
    cycle('0, '0, '0);
    n_cmp++;
    if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow_err); end
  endtask
`else
  task automatic test_double_free();
    do_reset();
    cycle('0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd30});
    n_cmp++;
    if (double_free_err !== 1'b1) begin n_fail++; $display("FAIL dfe_set: got %b expected 1", double_free_err); end
    n_cmp++;
    if (free_count !== 7'd63) begin n_fail++; $display("FAIL dfe_free_count: got %0d expected 63", free_count); end
  endtask
`endif

  task automatic test_random();
    logic [SLOTS-1:0]      r;
    logic [FW-1:0]         fv;
    logic [FW-1:0][PW-1:0] fd;
    int                    nv;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        // first half: light consumption, heavy release; second half: the reverse
        if (c < 200) begin
          r  = SLOTS'($urandom & $urandom & $urandom);
          fv = FW'($urandom);
        end else begin
          r  = SLOTS'($urandom);
          fv = ($urandom_range(0, 1) == 1) ? FW'($urandom & $urandom) : '0;
        end
        for (int l = 0; l < FW; l++) fd[l] = PW'($urandom_range(0, N - 1));
        cycle(r, fv, fd);
      end
      nv = 0;
      for (int k = 0; k < SLOTS; k++) begin
        nv += int'(m_vld[k]);
        if (m_vld[k]) begin
          n_cmp++;
          if (free_register_data[k] !== PW'(m_idx[k])) begin
            n_fail++;
            $display("FAIL rand_slot%0d cyc%0d: got %0d expected %0d", k, c, free_register_data[k], m_idx[k]);
          end
        end
      end
      n_cmp++;
      if (frl_valid !== (&m_vld)) begin
        n_fail++;
        $display("FAIL rand_frl_valid cyc%0d: got %b expected %b", c, frl_valid, &m_vld);
      end
      n_cmp++;
      if (free_count !== (PW+1)'(nv + m_q.size())) begin
        n_fail++;
        $display("FAIL rand_free_count cyc%0d: got %0d expected %0d", c, free_count, nv + m_q.size());
      end
      n_cmp++;
      if (overflow_err !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_overflow cyc%0d: got %b expected %b", c, overflow_err, m_ovf);
      end
`ifdef FRL_DOUBLE_FREE_CHECK_EN
      n_cmp++;
      if (double_free_err !== m_dfe) begin
        n_fail++;
        $display("FAIL rand_dfe cyc%0d: got %b expected %b", c, double_free_err, m_dfe);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_partial_consume();
`ifndef FRL_DOUBLE_FREE_CHECK_EN
    test_drain_refill();
`endif
    test_simultaneous();
`ifndef FRL_DOUBLE_FREE_CHECK_EN
    test_overflow();
`else
    test_double_free();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
